// File: rtl/vector_pkg.sv
// Shared types for the vector line plotter: FSM state encoding and the
// width of the signed Bresenham error term derived from the channel width.
package vector_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      DRAW   = 2'd2,
      FINISH = 2'd3
   } state_t;

   // Two extra bits: one for the sign, one so that 2*err cannot overflow.
   function automatic int errWidth(input int chWidth);
      return chWidth + 2;
   endfunction

endpackage

// File: rtl/step_tick.sv
// Point-rate divider: counts 0..STEP_DIV-1 and flags the last count as a
// tick. Held at zero while clear is high so each segment starts aligned.
module step_tick #(
   parameter int STEP_DIV = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(STEP_DIV - 1);

   logic [15:0] countQ;
   logic [15:0] countD;

   assign tick = !clear && (countQ == LAST);

   // Next count: restart on clear or after the last count, else increment.
   always_comb begin
      countD = countQ;
      if (clear || (countQ == LAST)) begin
         countD = '0;
      end else begin
         countD = countQ + 16'd1;
      end
   end

   // Counter register, cleared asynchronously by the active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         countQ <= '0;
      end else begin
         countQ <= countD;
      end
   end

endmodule

// File: rtl/vector_line_draw.sv
// Vector line plotter: accepts one segment, walks the beam along it with
// Bresenham steps, holding each point for STEP_DIV clocks, then pulses done.
// Optional macro VECTOR_LINE_BLANK_EN adds a registered beam-blank output.
module vector_line_draw
   import vector_pkg::*;
#(
   parameter int CH_WIDTH = 8,
   parameter int STEP_DIV = 100
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CH_WIDTH-1:0] x0,
   input  logic [CH_WIDTH-1:0] y0,
   input  logic [CH_WIDTH-1:0] x1,
   input  logic [CH_WIDTH-1:0] y1,
   output logic [CH_WIDTH-1:0] x_ch,
   output logic [CH_WIDTH-1:0] y_ch,
   output logic                busy,
   output logic                done
`ifdef VECTOR_LINE_BLANK_EN
   ,
   output logic                blank
`endif
);

   localparam int ERR_W = errWidth(CH_WIDTH);
   localparam logic [CH_WIDTH-1:0] ONE = 1;

   state_t stateQ, stateD;
   logic [CH_WIDTH-1:0] xChQ, xChD, yChQ, yChD;
   logic [CH_WIDTH-1:0] x0Q, x0D, y0Q, y0D, x1Q, x1D, y1Q, y1D;
   logic signed [ERR_W-1:0] dxQ, dxD, dyQ, dyD, errQ, errD;
   logic signed [ERR_W-1:0] e2;
   logic sxNegQ, sxNegD, syNegQ, syNegD;
   logic [CH_WIDTH-1:0] absX, absY;
   logic tick;
   logic clearCnt;

   assign in_ready = (stateQ == IDLE);
   assign busy     = (stateQ != IDLE);
   assign done     = (stateQ == FINISH);
   assign x_ch     = xChQ;
   assign y_ch     = yChQ;

   assign absX     = (x1Q >= x0Q) ? (x1Q - x0Q) : (x0Q - x1Q);
   assign absY     = (y1Q >= y0Q) ? (y1Q - y0Q) : (y0Q - y1Q);
   assign e2       = errQ <<< 1;
   assign clearCnt = (stateQ != DRAW);

   step_tick #(
      .STEP_DIV(STEP_DIV)
   ) uStepTick (
      .clk  (clk),
      .rst  (rst),
      .clear(clearCnt),
      .tick (tick)
   );

   // Next-state and datapath: latch on accept, derive deltas, then step on ticks.
   always_comb begin
      stateD = stateQ;
      xChD   = xChQ;
      yChD   = yChQ;
      x0D    = x0Q;
      y0D    = y0Q;
      x1D    = x1Q;
      y1D    = y1Q;
      dxD    = dxQ;
      dyD    = dyQ;
      errD   = errQ;
      sxNegD = sxNegQ;
      syNegD = syNegQ;
      case (stateQ)
         IDLE: begin
            if (in_valid) begin
               x0D    = x0;
               y0D    = y0;
               x1D    = x1;
               y1D    = y1;
               xChD   = x0;
               yChD   = y0;
               stateD = SETUP;
            end
         end
         SETUP: begin
            dxD    = $signed({2'b00, absX});
            dyD    = -$signed({2'b00, absY});
            errD   = $signed({2'b00, absX}) - $signed({2'b00, absY});
            sxNegD = (x1Q < x0Q);
            syNegD = (y1Q < y0Q);
            stateD = DRAW;
         end
         DRAW: begin
            if (tick) begin
               if ((xChQ == x1Q) && (yChQ == y1Q)) begin
                  stateD = FINISH;
               end else begin
                  if (e2 >= dyQ) begin
                     errD = errD + dyQ;
                     xChD = sxNegQ ? (xChQ - ONE) : (xChQ + ONE);
                  end
                  if (e2 <= dxQ) begin
                     errD = errD + dxQ;
                     yChD = syNegQ ? (yChQ - ONE) : (yChQ + ONE);
                  end
               end
            end
         end
         FINISH: begin
            stateD = IDLE;
         end
         default: begin
            stateD = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any segment in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ <= IDLE;
         xChQ   <= '0;
         yChQ   <= '0;
         x0Q    <= '0;
         y0Q    <= '0;
         x1Q    <= '0;
         y1Q    <= '0;
         dxQ    <= '0;
         dyQ    <= '0;
         errQ   <= '0;
         sxNegQ <= 1'b0;
         syNegQ <= 1'b0;
      end else begin
         stateQ <= stateD;
         xChQ   <= xChD;
         yChQ   <= yChD;
         x0Q    <= x0D;
         y0Q    <= y0D;
         x1Q    <= x1D;
         y1Q    <= y1D;
         dxQ    <= dxD;
         dyQ    <= dyD;
         errQ   <= errD;
         sxNegQ <= sxNegD;
         syNegQ <= syNegD;
      end
   end

`ifdef VECTOR_LINE_BLANK_EN
   logic blankQ;
   logic blankD;

   assign blank = blankQ;

   // Beam is dark whenever the FSM is not presenting points.
   always_comb begin
      blankD = (stateD == IDLE) || (stateD == SETUP);
   end

   // Blank register tracks the state register, dark during reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blankQ <= 1'b1;
      end else begin
         blankQ <= blankD;
      end
   end
`endif

endmodule

// File: doc/vector_line_draw.md
VECTOR_LINE_DRAW -- requirements
Module: vector_line_draw

Interface
REQ-001 SHALL have parameter CH_WIDTH, default 8, width of every coordinate and channel.
REQ-002 SHALL have parameter STEP_DIV, default 100, clk cycles per plotted point (legal 2..65535).
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  segment request valid.
REQ-006 SHALL have port in_ready  output  1  block accepts a segment this cycle.
REQ-007 SHALL have ports x0, y0, x1, y1  input  CH_WIDTH each  segment start/end, unsigned.
REQ-008 SHALL have ports x_ch, y_ch  output  CH_WIDTH each  current beam position to DAC stage.
REQ-009 SHALL have port busy  output  1  segment in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse, segment finished.

Function
REQ-011 SHALL implement FSM states IDLE, SETUP, DRAW, FINISH.
REQ-012 in_ready SHALL equal (state == IDLE), combinationally; busy SHALL equal (state != IDLE).
REQ-013 IDLE: on in_valid && in_ready, SHALL latch x0..y1, load x_ch=x0, y_ch=y0 on that edge, go to SETUP.
REQ-014 SETUP (1 cycle): SHALL compute dx=|x1-x0|, dy=-|y1-y0|, sx/sy=+1/-1 by sign, err=dx+dy, in signed CH_WIDTH+2 bits; clear step counter; go to DRAW.
REQ-015 DRAW: step counter SHALL count 0..STEP_DIV-1; a step tick occurs when it equals STEP_DIV-1, then it wraps to 0.
REQ-016 On a tick, if (x_ch,y_ch)==(x1,y1) SHALL go to FINISH without moving; else SHALL apply one Bresenham step: e2=2*err; if e2>=dy then err+=dy, x_ch+=sx; if e2<=dx then err+=dx, y_ch+=sy (both may apply same tick).
REQ-017 First tick SHALL occur exactly STEP_DIV cycles after entering DRAW; each point held exactly STEP_DIV cycles.
REQ-018 A segment of max(|dx|,|dy|)=N SHALL present N+1 distinct points; x_ch/y_ch SHALL never leave the bounding box of the segment (no wrap-around at 0 or 2^CH_WIDTH-1).
REQ-019 Zero-length segment (start==end) SHALL present one point for STEP_DIV cycles, then FINISH.
REQ-020 FINISH (1 cycle): done=1, then IDLE; x_ch/y_ch SHALL hold the end point in IDLE until next accept.
REQ-021 in_valid and endpoint changes while busy SHALL be ignored; no queueing.
REQ-022 An accept in the cycle after FINISH SHALL be legal (back-to-back segments, one IDLE cycle between).

Reset
REQ-023 rst low SHALL asynchronously force state=IDLE, x_ch=0, y_ch=0, err=0, step counter=0, done=0, latched endpoints=0.
REQ-024 rst asserted mid-segment SHALL abort it with no done pulse; first accept possible on first rising edge with rst high.

Configuration
REQ-025 Macro VECTOR_LINE_BLANK_EN, when defined, SHALL add output blank (1 bit): 1 in IDLE, SETUP and during reset, 0 in DRAW and FINISH, registered with the FSM.
REQ-026 Without VECTOR_LINE_BLANK_EN the blank port and its logic SHALL not exist; all other behaviour identical.

Structure
REQ-027 Package vector_pkg SHALL hold the FSM state enum typedef and the signed error-width constant derivation.
REQ-028 The step counter/tick SHALL be a sub-module step_tick (parameter STEP_DIV, ports clk, rst, clear, tick); no derived clocks.

Verification (CH_WIDTH=8, STEP_DIV=4)
REQ-029 Reset mid-DRAW of (0,0)->(50,0) -> x_ch=y_ch=0, busy=0, in_ready=1 immediately; no done.
REQ-030 Segment (10,20)->(13,20) -> x_ch sequence 10,11,12,13 each held 4 cycles, y_ch=20, done one cycle after end point's hold, total busy = 1+16+1 cycles.
REQ-031 Segment (5,5)->(2,9) -> 5 points ending (2,9), each step |Δx|<=1, |Δy|<=1, y strictly increasing.
REQ-032 Segment (255,0)->(0,255) and (0,255)->(255,0) -> 256 points, no wrap, exact endpoints.
REQ-033 Zero-length (7,7)->(7,7) -> one point held 4 cycles, done pulse; in_valid held high during busy -> second segment accepted only after return to IDLE.
REQ-034 With VECTOR_LINE_BLANK_EN: blank=1 in IDLE/SETUP, 0 throughout DRAW of (0,0)->(3,3).
